// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one unified, variable-latency memory port between instruction
// fetch (IF) and data access (DM). Each transaction is started with a
// one-cycle mem_en pulse, and the memory finishes it with a one-cycle
// mem_done. The result goes back to the requester as a one-cycle
// valid or err pulse.
//
// Handshake: a requester raises *_req and holds req/addr/wr/wdata stable
// until it sees its one-cycle *_valid or *_err pulse. While it waits, its
// stall output stays high. The memory pulses mem_done for one cycle,
// at the earliest in the cycle mem_en is high. Read data is taken in that
// same cycle.
//
// Optional feature: define FAIR_ARB_EN to bound how many data grants in a
// row may starve an eligible fetch (MAX_DM_STREAK).
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr/if_flush/halt  fetch request side
//   dm_req/dm_wr/dm_addr/dm_wdata data request side
//   if_rdata/if_valid/if_err      fetch response (1-cycle pulses)
//   dm_rdata/dm_valid/dm_err      data response (1-cycle pulses)
//   stall_ins_mem/stall_data_mem  pipeline stalls
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata/mem_done  memory port
module mem_port_arbiter #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 16,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    input  logic              halt,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_err,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_err,
    output logic              stall_ins_mem,
    output logic              stall_data_mem,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_DM = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    // Current FSM state; kept as a plain named signal so checkers can bind to it.
    logic [1:0] state;
    logic       drop;        // the fetch in flight was flushed; discard its result
    logic       if_valid_r;  // registered fetch completion, before late-flush masking
    logic       if_elig;
    logic       grant_if;
    logic       grant_dm;

    assign if_elig = if_req & ~halt & ~if_flush;

`ifdef FAIR_ARB_EN
    logic [2:0] streak;      // DM grants in a row made while IF was eligible

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (if_elig && (!dm_req || streak == 3'(MAX_DM_STREAK))) begin
            grant_if = 1'b1;
        end else if (dm_req) begin
            grant_dm = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= 3'd0;
        end else if (state == IDLE) begin
            if (!if_elig || grant_if) begin
                streak <= 3'd0;
            end else if (grant_dm && streak != 3'd7) begin
                streak <= streak + 3'd1;
            end
        end
    end
`else
    // Data always wins over fetch.
    always_comb begin
        grant_dm = dm_req;
        grant_if = if_elig & ~dm_req;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            drop       <= 1'b0;
            if_valid_r <= 1'b0;
            if_err     <= 1'b0;
            dm_valid   <= 1'b0;
            dm_err     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // Pulses last a single cycle unless set again below.
            mem_en     <= 1'b0;
            if_valid_r <= 1'b0;
            if_err     <= 1'b0;
            dm_valid   <= 1'b0;
            dm_err     <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_dm) begin
                        if (dm_addr[0]) begin
                            // An odd address never reaches memory.
                            dm_err   <= 1'b1;
                            dm_rdata <= '0;
                            state    <= RESP;
                        end else begin
                            mem_addr  <= dm_addr;
                            mem_wr    <= dm_wr;
                            mem_wdata <= dm_wdata;
                            mem_en    <= 1'b1;
                            state     <= BUSY_DM;
                        end
                    end else if (grant_if) begin
                        if (if_addr[0]) begin
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                            state    <= RESP;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wr    <= 1'b0;
                            mem_wdata <= '0;
                            mem_en    <= 1'b1;
                            state     <= BUSY_IF;
                        end
                    end
                end
                BUSY_IF: begin
                    if (if_flush) begin
                        drop <= 1'b1;
                    end
                    // The memory must still finish the access, even if the fetch was flushed.
                    if (mem_done) begin
                        if_rdata   <= mem_rdata;
                        if_valid_r <= ~(drop | if_flush);
                        state      <= RESP;
                    end
                end
                BUSY_DM: begin
                    if (mem_done) begin
                        dm_rdata <= mem_wr ? '0 : mem_rdata;
                        dm_valid <= 1'b1;
                        state    <= RESP;
                    end
                end
                default: begin
                    // RESP: the response pulses are visible this cycle.
                    drop  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A redirect that arrives in the response cycle still cancels the fetch.
    assign if_valid       = if_valid_r & ~if_flush;
    assign stall_ins_mem  = ~rst & if_req & ~(if_valid | if_err);
    assign stall_data_mem = ~rst & dm_req & ~(dm_valid | dm_err);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_flush = 1'b0;
  logic          halt = 1'b0;
  logic          dm_req = 1'b0;
  logic          dm_wr = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          if_valid, if_err, dm_valid, dm_err;
  logic          stall_ins_mem, stall_data_mem;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_done;
  logic          mem_done_m = 1'b0;
  logic          mem_done_inj = 1'b0;

  assign mem_done = mem_done_m | mem_done_inj;

  int n_checks = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .halt(halt),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err),
    .stall_ins_mem(stall_ins_mem), .stall_data_mem(stall_data_mem),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog");
  end

  // memory model: mem_done arrives mem_lat cycles after mem_en (0 = same cycle)
  int            mem_lat = 1;
  logic [DW-1:0] mem_data = '0;
  bit            pend = 0;
  int            cnt = 0;

  always begin
    @(posedge clk);
    #2;
    mem_done_m = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (mem_en) begin
        pend = 1;
        cnt = mem_lat;
      end else if (pend && cnt > 0) begin
        cnt--;
      end
      if (pend && cnt == 0) begin
        mem_done_m = 1'b1;
        mem_rdata = mem_data;
        pend = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            is_dm;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] mdata;
    int            halt_n;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_cyc;
  } vec_t;

  // driver: one transaction, cycle 0 = first cycle the request is seen in IDLE
  task automatic run_txn(input vec_t v);
    int men_exp;
    bit done;
    men_exp = v.exp_err ? -1 : v.halt_n + 1;
    mem_lat = v.lat;
    mem_data = v.mdata;
    @(posedge clk); #1;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_wr = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      halt = (c < v.halt_n);
      @(negedge clk);
      if (mem_en) begin
        check("mem_en_cycle", 32'(c), 32'(men_exp));
        check("mem_wr", {31'd0, mem_wr}, {31'd0, v.is_dm & v.wr});
        check("mem_addr", {16'd0, mem_addr}, {16'd0, v.addr});
        if (v.is_dm && v.wr) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
      end
      if (if_valid | if_err | dm_valid | dm_err) begin
        done = 1;
        check("done_cycle", 32'(c), 32'(v.exp_cyc));
        check("err_flag", {31'd0, v.is_dm ? dm_err : if_err}, {31'd0, v.exp_err});
        check("valid_flag", {31'd0, v.is_dm ? dm_valid : if_valid}, {31'd0, !v.exp_err});
        check("other_side_quiet", {31'd0, v.is_dm ? (if_valid | if_err) : (dm_valid | dm_err)}, 32'd0);
        check("rdata", {16'd0, v.is_dm ? dm_rdata : if_rdata}, {16'd0, v.exp_rdata});
        check("stall_released", {31'd0, v.is_dm ? stall_data_mem : stall_ins_mem}, 32'd0);
      end else begin
        check("stall_waiting", {31'd0, v.is_dm ? stall_data_mem : stall_ins_mem}, 32'd1);
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("txn_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; halt = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    int dm_c, if_c, en_cnt, dm_cnt, ifv, dm_at_if;
    bit stop;

    // directed vectors: is_dm wr addr wdata lat mdata halt_n | err rdata cycle
    tbl[0] = '{0, 0, 16'h0010, 16'h0000, 1, 16'h1234, 0, 0, 16'h1234, 3};
    tbl[1] = '{1, 0, 16'h0100, 16'h0000, 0, 16'hCAFE, 0, 0, 16'hCAFE, 2};
    tbl[2] = '{1, 0, 16'h0101, 16'h0000, 1, 16'h1111, 0, 1, 16'h0000, 1};
    tbl[3] = '{0, 0, 16'h0011, 16'h0000, 1, 16'h2222, 0, 1, 16'h0000, 1};
    tbl[4] = '{1, 1, 16'h0300, 16'hBEEF, 2, 16'h7777, 0, 0, 16'h0000, 4};
    tbl[5] = '{0, 0, 16'h0400, 16'h0000, 4, 16'h0F0F, 0, 0, 16'h0F0F, 6};
    tbl[6] = '{0, 0, 16'h0500, 16'h0000, 1, 16'h4321, 2, 0, 16'h4321, 5};
    tbl[7] = '{1, 0, 16'hFFFE, 16'h0000, 3, 16'h8001, 0, 0, 16'h8001, 5};

    // reset with both requests raised: stalls must stay low, outputs zero
    if_req = 1'b1; dm_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall_ins", {31'd0, stall_ins_mem}, 32'd0);
    check("rst_stall_data", {31'd0, stall_data_mem}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_pulses", {28'd0, if_valid, if_err, dm_valid, dm_err}, 32'd0);
    check("rst_rdata", {if_rdata, dm_rdata}, 32'd0);
    if_req = 1'b0; dm_req = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // contention: DM served first, IF granted in the following IDLE
    mem_lat = 1; mem_data = 16'h3C3C;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
    dm_c = -1; if_c = -1; en_cnt = 0;
    for (int c = 0; c < 20 && if_c < 0; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (en_cnt == 1) begin
          check("cont_first_addr", {16'd0, mem_addr}, 32'h0100);
          check("cont_first_en_cycle", 32'(c), 32'd1);
        end else begin
          check("cont_second_addr", {16'd0, mem_addr}, 32'h0020);
          check("cont_second_en_cycle", 32'(c), 32'd5);
        end
      end
      if (dm_valid) begin
        dm_c = c;
        check("cont_dm_rdata", {16'd0, dm_rdata}, 32'h3C3C);
      end
      if (if_valid) begin
        if_c = c;
        check("cont_if_rdata", {16'd0, if_rdata}, 32'h3C3C);
      end else begin
        check("cont_stall_ins", {31'd0, stall_ins_mem}, 32'd1);
      end
      @(posedge clk); #1;
      if (dm_c >= 0) dm_req = 1'b0;
    end
    if_req = 1'b0;
    check("cont_dm_cycle", 32'(dm_c), 32'd3);
    check("cont_if_cycle", 32'(if_c), 32'd7);

    // flush mid-fetch with a 4-cycle memory: first result dropped, new address fetched
    mem_lat = 3; mem_data = 16'h0A0A;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0040;
    if_c = -1; en_cnt = 0;
    for (int c = 0; c < 20 && if_c < 0; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (en_cnt == 1) begin
          check("flush_first_en_cycle", 32'(c), 32'd1);
          check("flush_first_addr", {16'd0, mem_addr}, 32'h0040);
        end else begin
          check("flush_second_en_cycle", 32'(c), 32'd7);
          check("flush_second_addr", {16'd0, mem_addr}, 32'h0080);
        end
      end
      if (if_valid) begin
        if_c = c;
        check("flush_rdata", {16'd0, if_rdata}, 32'h0A0A);
      end
      @(posedge clk); #1;
      if_flush = (c + 1 == 2);
      if (c + 1 == 2) if_addr = 16'h0080;
    end
    if_req = 1'b0;
    check("flush_valid_cycle", 32'(if_c), 32'd11);
    check("flush_mem_en_count", 32'(en_cnt), 32'd2);

    // flush in the response cycle suppresses that cycle's if_valid
    mem_lat = 1; mem_data = 16'h6060;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0060;
    repeat (3) @(posedge clk);
    #1;
    if_flush = 1'b1;
    @(negedge clk);
    check("resp_flush_valid", {31'd0, if_valid}, 32'd0);
    check("resp_flush_stall", {31'd0, stall_ins_mem}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; if_flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("resp_flush_quiet", {30'd0, mem_en, if_valid}, 32'd0);
    end

    // async reset while BUSY_DM: outputs clear at once, a stray mem_done is ignored
    mem_lat = 5; mem_data = 16'h9999;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200;
    @(negedge clk);
    @(negedge clk);
    check("busy_dm_mem_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("async_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("async_rst_stall_data", {31'd0, stall_data_mem}, 32'd0);
    check("async_rst_pulses", {28'd0, if_valid, if_err, dm_valid, dm_err}, 32'd0);
    dm_req = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rdata = 16'hDEAD;
    mem_done_inj = 1'b1;
    @(posedge clk); #1;
    mem_done_inj = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stray_done_ignored", {27'd0, mem_en, if_valid, if_err, dm_valid, dm_err}, 32'd0);
    end
    run_txn(tbl[0]);

    // both requests held continuously with a fast memory
    mem_lat = 0; mem_data = 16'h5555;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0070;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0080;
    dm_cnt = 0; ifv = 0; dm_at_if = -1; stop = 0;
    for (int c = 0; c < 80 && !stop; c++) begin
      @(negedge clk);
      if (dm_valid) dm_cnt++;
      if (if_valid) begin
        ifv++;
        dm_at_if = dm_cnt;
      end
`ifdef FAIR_ARB_EN
      stop = (ifv > 0);
`else
      stop = (dm_cnt == 6);
`endif
      @(posedge clk); #1;
    end
    if_req = 1'b0; dm_req = 1'b0;
`ifdef FAIR_ARB_EN
    check("fair_dm_grants_before_if", 32'(dm_at_if), 32'd4);
`else
    check("strict_if_starved", 32'(ifv), 32'd0);
    check("strict_dm_count", 32'(dm_cnt), 32'd6);
`endif
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
